// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encodings and constants for the imem_ctrl responder
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10,
    GAP  = 2'b11
  } imem_state_e;

  localparam int IMEM_DEF_LATENCY = 2;
  localparam int IMEM_CNT_WIDTH   = 4;

endpackage

// File: rtl/imem_lat_counter.sv
// rtl/imem_lat_counter.sv - loadable 4-bit down-counter timing the BUSY phase of imem_ctrl
module imem_lat_counter
  import imem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [IMEM_CNT_WIDTH-1:0] load_val,
  input  logic                      dec,
  output logic                      zero
);

  logic [IMEM_CNT_WIDTH-1:0] cnt_q;
  logic [IMEM_CNT_WIDTH-1:0] cnt_d;

  // Saturates at zero so a stray decrement can never wrap into a long stall.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - single-port memory responder with fixed latency and shared tristate data bus
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int MEM_DEPTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = IMEM_DEF_LATENCY,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
`ifdef IMEM_PARITY_EN
  input  logic                  par_inject,
  output logic                  parity_err,
`endif
  output logic                  data_valid,
  output logic                  busy
);

  localparam logic [IMEM_CNT_WIDTH-1:0] LOAD_VAL =
    (RD_LATENCY > 1) ? IMEM_CNT_WIDTH'(RD_LATENCY - 2) : '0;

  imem_state_e           state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  data_valid_q, data_valid_d;
  logic                  busy_q, busy_d;
  logic                  drive_q, drive_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic                  accept;
  logic                  addr_ok;
  logic                  mem_wr;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic [DATA_WIDTH-1:0] rdata;

  assign accept  = (state_q == IDLE) && req_valid;
  assign addr_ok = (32'(addr_q) < MEM_DEPTH);
  assign mem_wr  = (state_q == RESP) && we_q && addr_ok;

  imem_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are derived from the next state so they are registered yet aligned with it.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = data;
          if (RD_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d  = BUSY;
            cnt_load = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    drive_d      = (state_d == RESP) && !we_d;
  end

  // The write lands on the RESP exit edge, ahead of any following accept.
  always_comb begin
    mem_d = mem_q;
    if (mem_wr) begin
      mem_d[addr_q] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      drive_q      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      drive_q      <= drive_d;
      mem_q        <= mem_d;
    end
  end

  assign rdata      = addr_ok ? mem_q[addr_q] : '0;
  assign data       = drive_q ? rdata : 'z;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;

`ifdef IMEM_PARITY_EN
  logic inj_q, inj_d;
  logic mem_par_q [MEM_DEPTH];
  logic mem_par_d [MEM_DEPTH];
  logic parity_err_q, parity_err_d;
  logic addr_ok_d;

  assign addr_ok_d = (32'(addr_d) < MEM_DEPTH);

  // Memory is stable while entering RESP, so the check can use the word at addr_d.
  always_comb begin
    inj_d = inj_q;
    if (accept) begin
      inj_d = par_inject;
    end
    mem_par_d = mem_par_q;
    if (mem_wr) begin
      mem_par_d[addr_q] = (^wdata_q) ^ inj_q;
    end
    parity_err_d = drive_d && addr_ok_d && (mem_par_q[addr_d] != (^mem_q[addr_d]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q        <= 1'b0;
      parity_err_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_par_q[i] <= 1'b0;
      end
    end else begin
      inj_q        <= inj_d;
      parity_err_q <= parity_err_d;
      mem_par_q    <= mem_par_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed self-checking bench for imem_ctrl at latencies 2, 1 and 4
// Parity vectors are included when IMEM_PARITY_EN is defined.
module tb_imem_ctrl;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam logic [DW-1:0] BUS_IDLE = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [3];
  logic          req  [3];
  logic          we   [3];
  logic [AW-1:0] addr [3];
  logic          drv  [3];
  logic [DW-1:0] wd   [3];
  wire           dv   [3];
  wire           bsy  [3];
  wire  [DW-1:0] obs  [3];
  wire  [DW-1:0] bus0, bus1, bus2;
`ifdef IMEM_PARITY_EN
  logic          pinj [3];
  wire           perr [3];
`endif

  int n_vec = 0;
  int n_err = 0;

  // Undriven bus floats to all ones, making high-Z observable.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (bus0[i]);
    pullup (bus1[i]);
    pullup (bus2[i]);
  end

  assign bus0 = drv[0] ? wd[0] : 'z;
  assign bus1 = drv[1] ? wd[1] : 'z;
  assign bus2 = drv[2] ? wd[2] : 'z;
  assign obs[0] = bus0;
  assign obs[1] = bus1;
  assign obs[2] = bus2;

  imem_ctrl #(.RD_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst[0]), .req_valid(req[0]), .we(we[0]), .addr(addr[0]), .data(bus0),
`ifdef IMEM_PARITY_EN
    .par_inject(pinj[0]), .parity_err(perr[0]),
`endif
    .data_valid(dv[0]), .busy(bsy[0])
  );

  imem_ctrl #(.RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst[1]), .req_valid(req[1]), .we(we[1]), .addr(addr[1]), .data(bus1),
`ifdef IMEM_PARITY_EN
    .par_inject(pinj[1]), .parity_err(perr[1]),
`endif
    .data_valid(dv[1]), .busy(bsy[1])
  );

  imem_ctrl #(.RD_LATENCY(4)) u_lat4 (
    .clk(clk), .reset(rst[2]), .req_valid(req[2]), .we(we[2]), .addr(addr[2]), .data(bus2),
`ifdef IMEM_PARITY_EN
    .par_inject(pinj[2]), .parity_err(perr[2]),
`endif
    .data_valid(dv[2]), .busy(bsy[2])
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request from IDLE; returns read data, cycles to data_valid (0 = timeout), parity flag.
  task automatic access(input int k, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wdat, input bit inj,
                        output logic [DW-1:0] rd, output int lat, output bit pe);
    bit z_ok;
    z_ok = 1'b1;
    lat  = 0;
    rd   = '0;
    pe   = 1'b0;
    @(negedge clk);
    req[k]  = 1'b1;
    we[k]   = w;
    addr[k] = a;
    wd[k]   = wdat;
    drv[k]  = w;
`ifdef IMEM_PARITY_EN
    pinj[k] = inj;
`else
    if (inj) z_ok = 1'b1;
`endif
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      drv[k] = 1'b0;
      #1;
      if (dv[k] && !w) begin
        rd = obs[k];
      end else if (obs[k] !== BUS_IDLE) begin
        z_ok = 1'b0;
      end
      if (dv[k]) begin
        lat = c;
`ifdef IMEM_PARITY_EN
        pe = perr[k];
`endif
      end
    end
    req[k] = 1'b0;
    we[k]  = 1'b0;
`ifdef IMEM_PARITY_EN
    pinj[k] = 1'b0;
`endif
    chk("bus high-z outside read pulse", 32'(z_ok), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    int lat, cnt, last, nxt;
    bit pe, seen;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; drv[k] = 1'b0; wd[k] = '0;
`ifdef IMEM_PARITY_EN
      pinj[k] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset data_valid", 32'(dv[0]), 32'd0);
    chk("reset busy", 32'(bsy[0]), 32'd0);
    chk("reset bus", obs[0], BUS_IDLE);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);

    // Latency 2: read after reset, write then read back.
    access(0, 1'b0, 3'd3, '0, 1'b0, rd, lat, pe);
    chk("read3 latency", 32'(lat), 32'd2);
    chk("read3 data", rd, 32'h0000_0000);
    access(0, 1'b1, 3'd5, 32'hDEAD_BEEF, 1'b0, rd, lat, pe);
    chk("write5 latency", 32'(lat), 32'd2);
    access(0, 1'b0, 3'd5, '0, 1'b0, rd, lat, pe);
    chk("read5 latency", 32'(lat), 32'd2);
    chk("read5 data", rd, 32'hDEAD_BEEF);

    // Latency 2: req_valid/we/addr wiggled in BUSY, RESP and GAP.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd5;
    cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      #1;
      if (dv[0]) begin
        cnt++;
        chk("toggle read data", obs[0], 32'hDEAD_BEEF);
        chk("toggle pulse cycle", 32'(n), 32'd2);
      end
      if (n == 1) chk("busy after accept", 32'(bsy[0]), 32'd1);
      if (n == 4) chk("busy low after gap", 32'(bsy[0]), 32'd0);
      req[0]  = (n == 2 || n == 3);
      we[0]   = 1'b1;
      addr[0] = 3'd0;
    end
    req[0] = 1'b0; we[0] = 1'b0;
    chk("toggle pulse count", 32'(cnt), 32'd1);
    access(0, 1'b0, 3'd0, '0, 1'b0, rd, lat, pe);
    chk("toggle no stray write", rd, 32'h0000_0000);

    // Latency 1: fill, then back-to-back reads with req_valid held high.
    for (int i = 0; i < 8; i++) begin
      access(1, 1'b1, AW'(i), 32'h0101_0101 * (i + 1), 1'b0, rd, lat, pe);
      if (i == 0) chk("lat1 write latency", 32'(lat), 32'd1);
    end
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd0;
    nxt = 0; last = -1; cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      #1;
      if (dv[1]) begin
        chk("b2b data", obs[1], 32'h0101_0101 * (nxt + 1));
        if (last >= 0) chk("b2b spacing", 32'(c - last), 32'd3);
        last = c;
        nxt++;
        cnt++;
        if (nxt == 8) req[1] = 1'b0;
        else addr[1] = AW'(nxt);
      end
    end
    req[1] = 1'b0;
    chk("b2b pulse count", 32'(cnt), 32'd8);

    // Latency 4: reset during BUSY of a write aborts it.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 3'd2; wd[2] = 32'h1234_5678; drv[2] = 1'b1;
    @(negedge clk);
    drv[2] = 1'b0;
    #1;
    chk("lat4 busy in BUSY", 32'(bsy[2]), 32'd1);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("abort data_valid", 32'(dv[2]), 32'd0);
    chk("abort busy", 32'(bsy[2]), 32'd0);
    chk("abort bus", obs[2], BUS_IDLE);
    req[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (dv[2]) seen = 1'b1;
    end
    chk("abort no pulse", 32'(seen), 32'd0);
    access(2, 1'b0, 3'd2, '0, 1'b0, rd, lat, pe);
    chk("lat4 read latency", 32'(lat), 32'd4);
    chk("abort no write", rd, 32'h0000_0000);

`ifdef IMEM_PARITY_EN
    access(0, 1'b1, 3'd1, 32'h0000_0001, 1'b1, rd, lat, pe);
    access(0, 1'b0, 3'd1, '0, 1'b0, rd, lat, pe);
    chk("parity injected data", rd, 32'h0000_0001);
    chk("parity injected err", 32'(pe), 32'd1);
    access(0, 1'b1, 3'd2, 32'h0000_0001, 1'b0, rd, lat, pe);
    access(0, 1'b0, 3'd2, '0, 1'b0, rd, lat, pe);
    chk("parity clean err", 32'(pe), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Single-port instruction/data memory responder that sits directly upstream of the fetch stage and answers its requests. It accepts one request (`req_valid`, `we`, `addr`, shared bidirectional `data`) at a time. After a fixed, parameterised latency it completes the access and signals completion with a one-cycle `data_valid` pulse. On reads it drives `data` only during that pulse.

## Interface
- `MEM_DEPTH`, 8: number of words; `ADDR_WIDTH = $clog2(MEM_DEPTH)`.
- `DATA_WIDTH`, 32: word width.
- `RD_LATENCY`, 2: cycles from request acceptance to `data_valid`; legal range 1..15.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present; requester holds it high until `data_valid`.
- `we`  in  1  1 = write, 0 = read; sampled at acceptance.
- `addr`  in  ADDR_WIDTH  word address; sampled at acceptance.
- `data`  inout  DATA_WIDTH  write data in (sampled at acceptance); read data out during the read `data_valid` cycle; high-Z otherwise.
- `data_valid`  out  1  one-cycle completion pulse (read and write).
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, BUSY, RESP, GAP. State encoding is 2 bits.
- IDLE, `req_valid` = 1: latch `we`, `addr` and `data` into `we_q`, `addr_q` and `wdata_q`.
  - If `RD_LATENCY` = 1, next state is RESP.
  - Otherwise, next state is BUSY and `cnt` loads `RD_LATENCY-2`.
- BUSY: `cnt` decrements each cycle. When `cnt` = 0, next state is RESP.
- RESP: `data_valid` = 1.
  - Read: `data` is driven with `mem[addr_q]`.
  - Write: `mem[addr_q]` is written with `wdata_q` on the exit edge; `data` stays high-Z.
  - Next state is GAP.
- GAP: `req_valid` is ignored for one cycle, which absorbs requester deassert lag. Next state is IDLE.
- A request is accepted only in IDLE. Changes to `req_valid`, `addr` or `we` in other states have no effect.
- Out of range (`addr` ≥ `MEM_DEPTH`, only possible when `MEM_DEPTH` is not a power of 2):
  - Read returns 0.
  - Write is dropped.
  - `data_valid` still pulses.
- Read of a location written by the immediately preceding request returns the new value, because the write completes before the next accept.

## Timing
- Reset values: state = IDLE, `data_valid` = 0, `busy` = 0, `data` = high-Z, `cnt` = 0, all memory words = 0.
- Reset asserted mid-operation: the access is aborted, no memory write occurs, and the outputs take their reset values immediately (asynchronous).
- Accept on edge t → `data_valid` high during cycle t+`RD_LATENCY` (edge t+`RD_LATENCY-1` to edge t+`RD_LATENCY`).
- Throughput: one access per `RD_LATENCY`+2 cycles at most.
- `busy` rises the cycle after accept and falls when GAP exits.
- `data` drive enable is registered, identical in timing to `data_valid`, and gated by `!we_q`.

## Configuration
- Macro: `IMEM_PARITY_EN`.
- Defined:
  - Each word stores an extra even-parity bit, computed from `wdata_q` at write.
  - Extra input `par_inject` (1 bit), sampled at acceptance with a write: the stored parity bit is inverted.
  - Extra output `parity_err` (1 bit): high only in a read RESP cycle whose stored parity mismatches the recomputed parity of the read data. Reset value 0.
- Undefined: no parity storage, no `par_inject` port, no `parity_err` port. All other behaviour is identical.

## Structure
- Shared package `imem_pkg`:
  - State encodings: IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10, GAP = 2'b11.
  - `IMEM_DEF_LATENCY` = 2.
- Sub-module `imem_lat_counter`: a loadable down-counter (4-bit) with `load`, `load_val` and `zero` outputs, used by the BUSY state.
- Memory array, FSM and tristate driver are in `imem_ctrl`.

## Test plan
- Reset, then read from `addr` 3 → `data` = 0x00000000 with `data_valid` at accept+2; `data` is high-Z on all other cycles.
- Write 0xDEADBEEF to `addr` 5, then read `addr` 5 → `data_valid` pulses for both accesses; the read returns 0xDEADBEEF.
- `RD_LATENCY` = 1, back-to-back reads of `addr` 0..7 with `req_valid` held high continuously → one `data_valid` every 3 cycles, and each address is returned exactly once.
- `RD_LATENCY` = 4, reset asserted in BUSY during a write of 0x12345678 to `addr` 2 → no `data_valid`; a later read of `addr` 2 returns 0.
- `req_valid` toggled during BUSY, RESP and GAP → no extra acceptance and no extra `data_valid`.
- With `IMEM_PARITY_EN` defined, write 0x1 to `addr` 1 with `par_inject` = 1, then read → `parity_err` = 1 coincident with `data_valid`. Write 0x1 to `addr` 2 with `par_inject` = 0, then read → `parity_err` = 0.
